// File: rtl/top_controller.sv
// top_controller: UART command controller with RAM access and a CORDIC sin/cos engine.
//
// Ports
//   clk_100Mhz : system clock, all logic on its rising edge
//   reset      : asynchronous, active-high reset
//   rx_in      : UART receive line (8N1, LSB first, idle high)
//   tx_out     : UART transmit line (8N1, LSB first, idle high)
//
// Commands (one reply frame per byte listed)
//   'W' addr data -> RAM[addr] = data, reply 0x06
//   'R' addr      -> reply RAM[addr]
//   'C' angle     -> reply sin, cos (signed Q1.6), angle = a*(pi/2)/128 rad
//   anything else -> reply 0x15
//
// Command FSM
//   state      | meaning
//   IDLE       | waiting for a command byte
//   GET_ADDR   | waiting for the address byte of 'W' or 'R'
//   GET_DATA   | waiting for the data byte of 'W' or the angle byte of 'C'
//   RAM_RD     | RAM read data becomes valid, queue it
//   CORDIC_RUN | one rotation per cycle until all iterations are done
//   SEND       | transmitting the queued reply bytes back-to-back
module top_controller #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CORDIC_ITER  = 14
) (
   input  logic clk_100Mhz,
   input  logic reset,
   input  logic rx_in,
   output logic tx_out
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_C = 8'h43;

   // ---------------- rx synchronizer ----------------
   // Reset to 0 so the receiver cannot arm until the real line is seen high.
   logic rx_m, rx_s;
   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b0;
         rx_s <= 1'b0;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
      end
   end

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   rx_state_t     rx_state, rx_state_nxt;
   logic [CW-1:0] rx_cnt, rx_cnt_nxt;
   logic [2:0]    rx_bitn, rx_bitn_nxt;
   logic [7:0]    rx_shift, rx_shift_nxt;
   logic          rx_armed, rx_armed_nxt;
   logic          rx_valid, rx_valid_nxt;

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bitn  <= '0;
         rx_shift <= '0;
         rx_armed <= 1'b0;
         rx_valid <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_bitn  <= rx_bitn_nxt;
         rx_shift <= rx_shift_nxt;
         rx_armed <= rx_armed_nxt;
         rx_valid <= rx_valid_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = (rx_cnt != '0) ? rx_cnt - CW'(1) : rx_cnt;
      rx_bitn_nxt  = rx_bitn;
      rx_shift_nxt = rx_shift;
      rx_armed_nxt = rx_armed;
      rx_valid_nxt = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_armed) begin
               if (rx_s) rx_armed_nxt = 1'b1;
            end else if (!rx_s) begin
               rx_state_nxt = RX_START;
               rx_cnt_nxt   = HALF_LAST;
            end
         end
         RX_START: begin
            if (rx_cnt == '0) begin
               if (rx_s) begin
                  rx_state_nxt = RX_IDLE;
               end else begin
                  rx_state_nxt = RX_DATA;
                  rx_cnt_nxt   = BIT_LAST;
                  rx_bitn_nxt  = '0;
               end
            end
         end
         RX_DATA: begin
            if (rx_cnt == '0) begin
               rx_shift_nxt = {rx_s, rx_shift[7:1]};
               rx_cnt_nxt   = BIT_LAST;
               if (rx_bitn == 3'd7) rx_state_nxt = RX_STOP;
               else                 rx_bitn_nxt  = rx_bitn + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == '0) begin
               rx_state_nxt = RX_IDLE;
               // A low stop bit disarms: the next start needs the line high first.
               if (rx_s) rx_valid_nxt = 1'b1;
               else      rx_armed_nxt = 1'b0;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // ---------------- transmitter ----------------
   logic          tx_start;
   logic [7:0]    tx_byte;
   logic          tx_busy;
   logic [8:0]    tx_shift;
   logic [3:0]    tx_bits;
   logic [CW-1:0] tx_cnt;
   logic          tx_last;

   // Last cycle of the stop bit; a new frame may load here with no idle gap.
   assign tx_last = tx_busy && (tx_cnt == '0) && (tx_bits == 4'd0);

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         tx_out   <= 1'b1;
         tx_busy  <= 1'b0;
         tx_shift <= '0;
         tx_bits  <= '0;
         tx_cnt   <= '0;
      end else if (tx_start) begin
         tx_out   <= 1'b0;
         tx_shift <= {1'b1, tx_byte};
         tx_bits  <= 4'd9;
         tx_cnt   <= BIT_LAST;
         tx_busy  <= 1'b1;
      end else if (tx_busy) begin
         if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
         end else if (tx_bits == 4'd0) begin
            tx_busy <= 1'b0;
         end else begin
            tx_out   <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[8:1]};
            tx_bits  <= tx_bits - 4'd1;
            tx_cnt   <= BIT_LAST;
         end
      end
   end

   // ---------------- RAM (contents survive reset) ----------------
   logic [7:0] mem [256] = '{default: 8'h00};
   logic       ram_we;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   always_ff @(posedge clk_100Mhz) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- CORDIC ----------------
   // Angles: pi/2 = 16384, i.e. the command byte shifted left by 7.
   function automatic logic signed [15:0] atan_lut(input logic [4:0] i);
      case (i)
         5'd0:  atan_lut = 16'sd8192;
         5'd1:  atan_lut = 16'sd4836;
         5'd2:  atan_lut = 16'sd2555;
         5'd3:  atan_lut = 16'sd1297;
         5'd4:  atan_lut = 16'sd651;
         5'd5:  atan_lut = 16'sd326;
         5'd6:  atan_lut = 16'sd163;
         5'd7:  atan_lut = 16'sd81;
         5'd8:  atan_lut = 16'sd41;
         5'd9:  atan_lut = 16'sd20;
         5'd10: atan_lut = 16'sd10;
         5'd11: atan_lut = 16'sd5;
         5'd12: atan_lut = 16'sd3;
         5'd13: atan_lut = 16'sd1;
         5'd14: atan_lut = 16'sd1;
         default: atan_lut = 16'sd0;
      endcase
   endfunction

   // Q2.14 -> Q1.6 with round-half-up and clamp to [-64, 64].
   function automatic logic [7:0] to_q6(input logic signed [15:0] v);
      logic signed [16:0] r;
      r = ($signed({v[15], v}) + 17'sd128) >>> 8;
      if (r > 17'sd64)       to_q6 = 8'h40;
      else if (r < -17'sd64) to_q6 = 8'hC0;
      else                   to_q6 = r[7:0];
   endfunction

   logic               cordic_load, cordic_step, cordic_done;
   logic signed [15:0] cx, cy, cz;
   logic [4:0]         c_iter;

   assign cordic_done = (c_iter == 5'(CORDIC_ITER));

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         cx     <= '0;
         cy     <= '0;
         cz     <= '0;
         c_iter <= '0;
      end else if (cordic_load) begin
         cx     <= 16'sd9949;
         cy     <= '0;
         cz     <= {rx_shift[7], rx_shift, 7'b0};
         c_iter <= '0;
      end else if (cordic_step) begin
         if (cz[15]) begin
            cx <= cx + (cy >>> c_iter);
            cy <= cy - (cx >>> c_iter);
            cz <= cz + atan_lut(c_iter);
         end else begin
            cx <= cx - (cy >>> c_iter);
            cy <= cy + (cx >>> c_iter);
            cz <= cz - atan_lut(c_iter);
         end
         c_iter <= c_iter + 5'd1;
      end
   end

   // ---------------- command FSM ----------------
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, RAM_RD, CORDIC_RUN, SEND} cmd_state_t;
   cmd_state_t state, state_nxt;
   logic [7:0] cmd, cmd_nxt, addr, addr_nxt;
   logic [7:0] q0, q0_nxt, q1, q1_nxt;
   logic [1:0] q_cnt, q_cnt_nxt, q_idx, q_idx_nxt;

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cmd   <= '0;
         addr  <= '0;
         q0    <= '0;
         q1    <= '0;
         q_cnt <= '0;
         q_idx <= '0;
      end else begin
         state <= state_nxt;
         cmd   <= cmd_nxt;
         addr  <= addr_nxt;
         q0    <= q0_nxt;
         q1    <= q1_nxt;
         q_cnt <= q_cnt_nxt;
         q_idx <= q_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_nxt     = cmd;
      addr_nxt    = addr;
      q0_nxt      = q0;
      q1_nxt      = q1;
      q_cnt_nxt   = q_cnt;
      q_idx_nxt   = q_idx;
      ram_we      = 1'b0;
      ram_addr    = addr;
      ram_wdata   = rx_shift;
      tx_start    = 1'b0;
      tx_byte     = (q_idx == 2'd0) ? q0 : q1;
      cordic_load = 1'b0;
      cordic_step = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               cmd_nxt   = rx_shift;
               q_idx_nxt = 2'd0;
               case (rx_shift)
                  CMD_W, CMD_R: state_nxt = GET_ADDR;
                  CMD_C:        state_nxt = GET_DATA;
                  default: begin
                     q0_nxt    = 8'h15;
                     q_cnt_nxt = 2'd1;
                     state_nxt = SEND;
                  end
               endcase
            end
         end
         GET_ADDR: begin
            if (rx_valid) begin
               addr_nxt  = rx_shift;
               ram_addr  = rx_shift;
               state_nxt = (cmd == CMD_W) ? GET_DATA : RAM_RD;
            end
         end
         GET_DATA: begin
            if (rx_valid) begin
               if (cmd == CMD_C) begin
                  cordic_load = 1'b1;
                  state_nxt   = CORDIC_RUN;
               end else begin
                  ram_we    = 1'b1;
                  q0_nxt    = 8'h06;
                  q_cnt_nxt = 2'd1;
                  state_nxt = SEND;
               end
            end
         end
         RAM_RD: begin
            q0_nxt    = ram_rdata;
            q_cnt_nxt = 2'd1;
            state_nxt = SEND;
         end
         CORDIC_RUN: begin
            if (cordic_done) begin
               q0_nxt    = to_q6(cy);
               q1_nxt    = to_q6(cx);
               q_cnt_nxt = 2'd2;
               state_nxt = SEND;
            end else begin
               cordic_step = 1'b1;
            end
         end
         SEND: begin
            if (q_idx != q_cnt) begin
               if (!tx_busy || tx_last) begin
                  tx_start  = 1'b1;
                  q_idx_nxt = q_idx + 2'd1;
               end
            end else if (!tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_top_controller.sv
// Testbench for top_controller: drives UART frames into rx_in, decodes tx_out
// frames and compares them against hand-computed replies.
module tb_top_controller;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic reset, rx_in, tx_out;

   always #5 clk = ~clk;

   top_controller #(.CLKS_PER_BIT(CPB), .CORDIC_ITER(14)) dut (
      .clk_100Mhz(clk),
      .reset(reset),
      .rx_in(rx_in),
      .tx_out(tx_out)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stop_cyc = 0;
   bit mon_en = 1'b1;
   logic [7:0] got_q[$];
   int start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Frame decoder on tx_out.
   logic [7:0] mon_b;
   int mon_t0;
   initial begin
      forever begin
         @(negedge tx_out);
         #1 mon_t0 = cyc;
         repeat (CPB / 2) @(posedge clk);
         #1;
         if (mon_en) begin
            checks++;
            if (tx_out !== 1'b0) begin
               errors++;
               $display("FAIL tx_start_bit got %b required 0", tx_out);
            end
         end
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 mon_b[i] = tx_out;
         end
         repeat (CPB) @(posedge clk);
         #1;
         if (mon_en) begin
            checks++;
            if (tx_out !== 1'b1) begin
               errors++;
               $display("FAIL tx_stop_bit got %b required 1", tx_out);
            end
            got_q.push_back(mon_b);
            start_q.push_back(mon_t0);
         end
      end
   end

   initial begin
      #(90000 * 10);
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         tick(CPB);
      end
      stop_cyc = cyc;
      rx_in = stop_bit;
      tick(CPB);
      rx_in = 1'b1;
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b required %b", name, got, exp);
      end
   endtask

   task automatic check_quiet(input int id, input int n);
      tick(n);
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL quiet%0d extra frames got %0d required 0", id, got_q.size());
      end
      got_q.delete();
      start_q.delete();
   endtask

   task automatic wait_frames(input int id, input int n);
      int budget;
      budget = 40 * CPB;
      while (got_q.size() < n && budget > 0) begin
         tick(1);
         budget--;
      end
      checks++;
      if (got_q.size() < n) begin
         errors++;
         $display("FAIL vec%0d timeout frames got %0d required %0d", id, got_q.size(), n);
      end
   endtask

   task automatic check_byte(input int id, input int k, input logic [7:0] got,
                             input logic [7:0] exp, input int tol);
      int d;
      d = int'($signed(got)) - int'($signed(exp));
      checks++;
      if (d > tol || d < -tol) begin
         errors++;
         $display("FAIL vec%0d byte%0d got %h required %h tol %0d", id, k, got, exp, tol);
      end
   endtask

   task automatic run_cmd(input int id, input int n_in, input logic [23:0] din,
                          input int n_out, input logic [15:0] dexp, input int tol,
                          input bit chk_lat);
      int lat;
      got_q.delete();
      start_q.delete();
      for (int i = 0; i < n_in; i++) send_byte(din[8*i +: 8], 1'b1);
      wait_frames(id, n_out);
      if (chk_lat && start_q.size() > 0) begin
         lat = start_q[0] - stop_cyc;
         checks++;
         if (lat < CPB / 2 || lat > CPB / 2 + 8) begin
            errors++;
            $display("FAIL vec%0d latency got %0d required %0d..%0d", id, lat, CPB / 2, CPB / 2 + 8);
         end
      end
      if (n_out == 2 && start_q.size() == 2) begin
         checks++;
         if (start_q[1] - start_q[0] != 10 * CPB) begin
            errors++;
            $display("FAIL vec%0d gap got %0d required %0d", id, start_q[1] - start_q[0], 10 * CPB);
         end
      end
      for (int k = 0; k < n_out; k++) begin
         if (got_q.size() > 0) check_byte(id, k, got_q.pop_front(), dexp[8*k +: 8], tol);
      end
      check_quiet(id, 12 * CPB);
   endtask

   typedef struct {
      int          n_in;
      logic [23:0] din;   // first byte sent in bits 7:0
      int          n_out;
      logic [15:0] dexp;  // first reply in bits 7:0
      int          tol;
   } vec_t;

   vec_t vecs[13];
   int budget;

   initial begin
      vecs[0]  = '{1, 24'h0000D5, 1, 16'h0015, 0};  // unknown byte -> NAK
      vecs[1]  = '{3, 24'hA51057, 1, 16'h0006, 0};  // W 0x10 0xA5
      vecs[2]  = '{2, 24'h001052, 1, 16'h00A5, 0};  // R 0x10
      vecs[3]  = '{2, 24'h002052, 1, 16'h0000, 0};  // R unwritten
      vecs[4]  = '{2, 24'h000043, 2, 16'h4000, 2};  // C 0   -> 0, 1
      vecs[5]  = '{2, 24'h004043, 2, 16'h2D2D, 2};  // C pi/4
      vecs[6]  = '{2, 24'h00C043, 2, 16'h2DD3, 2};  // C -pi/4
      vecs[7]  = '{3, 24'h3CFF57, 1, 16'h0006, 0};  // W top address
      vecs[8]  = '{2, 24'h00FF52, 1, 16'h003C, 0};  // R top address
      vecs[9]  = '{2, 24'h000052, 1, 16'h0000, 0};  // R address 0
      vecs[10] = '{1, 24'h000041, 1, 16'h0015, 0};  // 'A' -> NAK
      vecs[11] = '{2, 24'h008043, 2, 16'h00C0, 2};  // C -pi/2 -> -1, 0
      vecs[12] = '{2, 24'h007F43, 2, 16'h0140, 2};  // C just below pi/2

      // Reset with the line low, then keep it low a while after release.
      reset = 1'b1;
      rx_in = 1'b0;
      tick(5);
      check_bit("reset_tx_high", tx_out, 1'b1);
      reset = 1'b0;
      tick(2 * CPB);
      rx_in = 1'b1;
      check_quiet(100, 30 * CPB);
      check_bit("idle_tx_high", tx_out, 1'b1);

      // Short low glitch must be rejected at the half-bit recheck.
      rx_in = 1'b0;
      tick(CPB / 4);
      rx_in = 1'b1;
      check_quiet(101, 30 * CPB);

      for (int v = 0; v < 13; v++)
         run_cmd(v, vecs[v].n_in, vecs[v].din, vecs[v].n_out, vecs[v].dexp, vecs[v].tol,
                 vecs[v].din[7:0] != 8'h43);

      // Frame error on an 'R' byte, then a valid read.
      got_q.delete();
      send_byte(8'h52, 1'b0);
      tick(2 * CPB);
      run_cmd(20, 2, 24'h001052, 1, 16'h00A5, 0, 1'b0);

      // Reset in the middle of a write: nothing written, FSM back in IDLE.
      got_q.delete();
      send_byte(8'h57, 1'b1);
      send_byte(8'h30, 1'b1);
      tick(CPB);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2 * CPB);
      run_cmd(21, 1, 24'h000077, 1, 16'h0015, 0, 1'b0);
      run_cmd(22, 2, 24'h003052, 1, 16'h0000, 0, 1'b0);

      // Reset while a NAK frame is on the line.
      got_q.delete();
      send_byte(8'hD5, 1'b1);
      budget = 4 * CPB;
      while (tx_out !== 1'b0 && budget > 0) begin
         tick(1);
         budget--;
      end
      check_bit("tx_frame_started", tx_out, 1'b0);
      tick(2 * CPB + CPB / 2);
      check_bit("tx_mid_frame_low", tx_out, 1'b0);
      mon_en = 1'b0;
      #2 reset = 1'b1;
      #1 check_bit("tx_async_reset", tx_out, 1'b1);
      tick(3);
      reset = 1'b0;
      tick(20 * CPB);
      check_bit("tx_after_reset", tx_out, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/top_controller.md
TOP_CONTROLLER -- requirements
Module: top_controller

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter CORDIC_ITER, default 14, number of CORDIC iterations.
REQ-003 SHALL have port clk_100Mhz, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_in, input, 1 bit: UART receive line, 8N1, LSB first, idle high.
REQ-006 SHALL have port tx_out, output, 1 bit: UART transmit line, 8N1, LSB first, idle high.

Function
REQ-007 SHALL pass rx_in through a 2-flop synchronizer before any use.
REQ-008 Receiver SHALL arm only after seeing the synchronized line high; it SHALL then detect a start bit on a high-to-low transition.
REQ-009 Receiver SHALL recheck the start bit at CLKS_PER_BIT/2; if the line is high there, it SHALL discard the event and return to idle.
REQ-010 Receiver SHALL sample the 8 data bits, then the stop bit, each CLKS_PER_BIT after the previous sample.
REQ-011 If the stop bit samples 0 (frame error), the receiver SHALL drop the byte, produce no rx_valid, and return to idle after the line goes high.
REQ-012 On a valid frame, the receiver SHALL give a 1-cycle rx_valid pulse with the byte, 1 cycle after the stop-bit sample.
REQ-013 SHALL contain a 256x8 single-port synchronous block RAM, initialized to all zeros at configuration; reset SHALL NOT clear it.
REQ-014 Command FSM states SHALL be: IDLE, GET_ADDR, GET_DATA, RAM_RD, CORDIC_RUN, SEND.
REQ-015 In IDLE, byte 0x57 ('W') SHALL go to GET_ADDR.
REQ-016 After 'W', the next byte is the address and the following byte is the data; the FSM SHALL write RAM[addr]=data and queue reply 0x06.
REQ-017 In IDLE, byte 0x52 ('R') SHALL go to GET_ADDR; on the address byte the FSM SHALL read the RAM (1-cycle read latency) and queue reply RAM[addr].
REQ-018 In IDLE, byte 0x43 ('C') SHALL take the next byte as a signed angle a, meaning a*(pi/2)/128 rad, range [-pi/2, pi/2).
REQ-019 After 'C' and the angle byte, the FSM SHALL run an iterative rotation-mode CORDIC: 16-bit signed datapath, Q2.14 x/y, x0=gain-compensated 0.60725, y0=0, CORDIC_ITER iterations of one cycle each, atan table in the same angle units.
REQ-020 After CORDIC completes, the FSM SHALL queue 2 reply bytes: sin then cos, each signed Q1.6 (value*64, rounded, saturated to [-64, 64]), within ±2 LSB of ideal.
REQ-021 Any other byte received in IDLE SHALL queue reply 0x15 (NAK).
REQ-022 In SEND, the FSM SHALL transmit the queued bytes back-to-back with no idle bits between them, then return to IDLE.
REQ-023 Bytes received while not in IDLE, GET_ADDR or GET_DATA SHALL be ignored.
REQ-024 There is no inter-byte timeout; a partial command SHALL wait indefinitely.
REQ-025 Transmitter frame SHALL be: start bit 0, 8 data bits LSB first, stop bit 1, each bit CLKS_PER_BIT cycles long.
REQ-026 The first reply start bit SHALL begin at most 4 cycles after the reply is queued (CORDIC latency excluded).

Reset
REQ-027 While reset is high: tx_out=1, receiver idle and disarmed, FSM=IDLE, transmitter idle, reply queue empty, CORDIC registers zero.
REQ-028 Reset asserted mid-frame or mid-command SHALL abort immediately with no partial write or reply; tx_out SHALL go high asynchronously.

Verification
V1: Hold rx_in=0 during reset, release reset, hold rx_in=1 -> tx_out stays 1; no spurious byte is received.
V2: Send byte 0xD5 -> tx_out carries one frame 0x15 (NAK).
V3: Send 'W',0x10,0xA5, then 'R',0x10 -> replies 0x06, then 0xA5.
V4: Send 'R',0x20 on unwritten RAM -> reply 0x00.
V5: Send 'C',0x00 -> replies 0x00,0x40; send 'C',0x40 -> replies 0x2D,0x2D (±2 each); send 'C',0xC0 -> replies 0xD3,0x2D (±2 each).
V6: Send a frame with stop bit 0, then a valid 'R',0x10 -> only the reply 0xA5 is transmitted; asserting reset during a transmission forces tx_out=1 at once.
